// File: rtl/omsp_spm_seq_ctrl_pkg.sv
// Opcodes, FSM encodings and half-open region helpers shared by the SPM controller and its slots.
`ifndef OMSP_SPM_SEQ_CTRL_PKG_SV
`define OMSP_SPM_SEQ_CTRL_PKG_SV

// Regions are half-open: [a,b) and [c,d) overlap iff a<d && c<b.
`define SPM_OVERLAP(a, b, c, d) (((a) < (d)) && ((c) < (b)))
`define SPM_CONTAINS(s, e, x)   (((x) >= (s)) && ((x) < (e)))

package omsp_spm_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_ENABLE  = 2'b01,
        OP_DISABLE = 2'b10,
        OP_QUERY   = 2'b11
    } spm_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_RESP = 2'b10
    } spm_state_e;

endpackage

`endif

// File: rtl/omsp_spm_slot.sv
// One protected-module slot: enable bit, public/secret bounds and ID, plus its own
// per-cycle access/entry violation and the contains/overlaps terms used by the scan.
module omsp_spm_slot #(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_pub_s,
    input  logic [ADDR_W-1:0] i_pub_e,
    input  logic [ADDR_W-1:0] i_sec_s,
    input  logic [ADDR_W-1:0] i_sec_e,
    input  logic [ID_W-1:0]   i_id,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_prev_pc,
    input  logic [ADDR_W-1:0] i_mab,
    input  logic              i_mb_en,
    input  logic [ADDR_W-1:0] i_chk_addr,
    output logic              o_en,
    output logic [ID_W-1:0]   o_id,
    output logic              o_contains,
    output logic              o_overlaps,
    output logic              o_viol
);

    logic              r_en;
    logic [ADDR_W-1:0] r_pub_s, r_pub_e, r_sec_s, r_sec_e;
    logic [ID_W-1:0]   r_id;
    logic              w_pc_in_pub, w_prev_in_pub, w_mab_in_sec;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_en    <= 1'b0;
            r_pub_s <= '0;
            r_pub_e <= '0;
            r_sec_s <= '0;
            r_sec_e <= '0;
            r_id    <= '0;
        end else if (i_wr) begin
            r_en    <= 1'b1;
            r_pub_s <= i_pub_s;
            r_pub_e <= i_pub_e;
            r_sec_s <= i_sec_s;
            r_sec_e <= i_sec_e;
            r_id    <= i_id;
        end
    end

    assign w_pc_in_pub   = `SPM_CONTAINS(r_pub_s, r_pub_e, i_pc);
    assign w_prev_in_pub = `SPM_CONTAINS(r_pub_s, r_pub_e, i_prev_pc);
    assign w_mab_in_sec  = `SPM_CONTAINS(r_sec_s, r_sec_e, i_mab);

    assign o_en       = r_en;
    assign o_id       = r_id;
    assign o_contains = r_en && `SPM_CONTAINS(r_pub_s, r_pub_e, i_chk_addr);
    // The candidate regions arrive on the same bus that later commits them.
    assign o_overlaps = r_en && (`SPM_OVERLAP(r_pub_s, r_pub_e, i_pub_s, i_pub_e) ||
                                 `SPM_OVERLAP(r_pub_s, r_pub_e, i_sec_s, i_sec_e) ||
                                 `SPM_OVERLAP(r_sec_s, r_sec_e, i_pub_s, i_pub_e) ||
                                 `SPM_OVERLAP(r_sec_s, r_sec_e, i_sec_s, i_sec_e));
    assign o_viol     = r_en && ((i_mb_en && w_mab_in_sec && !w_pc_in_pub) ||
                                 (w_pc_in_pub && !w_prev_in_pub && (i_pc != r_pub_s)));

endmodule

// File: rtl/omsp_spm_seq_ctrl.sv
// Sequential SPM controller: enable/disable/query requests scan one slot per cycle
// (accept-to-done NB_SPMS+2 cycles); requests arriving while busy are dropped.
module omsp_spm_seq_ctrl
    import omsp_spm_seq_ctrl_pkg::*;
#(
    parameter int NB_SPMS = 4,
    parameter int ADDR_W  = 16,
    parameter int ID_W    = 16
) (
    input  logic              mclk,
    input  logic              puc_rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] eu_mab,
    input  logic              eu_mb_en,
    input  logic [1:0]        eu_mb_wr,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] r12,
    input  logic [ADDR_W-1:0] r13,
    input  logic [ADDR_W-1:0] r14,
    input  logic [ADDR_W-1:0] r15,
    output logic              busy,
    output logic              done,
    output logic              result_ok,
    output logic [ID_W-1:0]   result_data,
    output logic              violation
);

    localparam int IDX_W = (NB_SPMS > 1) ? $clog2(NB_SPMS) : 1;

    spm_state_e        r_state, w_state_nxt;
    spm_op_e           r_op;
    logic [ADDR_W-1:0] r_pub_s, r_pub_e, r_sec_s, r_sec_e, r_qaddr, r_req_pc, r_prev_pc;
    logic [IDX_W-1:0]  r_k, r_free_idx, r_hit_idx;
    logic              r_ovl, r_free, r_hit;
    logic [ID_W-1:0]   r_next_id, r_data;
    logic              r_done, r_ok, r_violation;

    logic                w_accept, w_scan_last, w_enable_ok, w_unused;
    logic [ADDR_W-1:0]   w_chk_addr;
    logic [NB_SPMS-1:0]  w_en, w_contains, w_overlaps, w_viol, w_wr, w_clr;
    logic [ID_W-1:0]     w_id [NB_SPMS];

    // Byte strobes are irrelevant: reads and writes into a secret region are equally illegal.
    assign w_unused    = ^eu_mb_wr;
    assign w_accept    = (r_state == ST_IDLE) && req_valid && (req_op != 2'b00);
    assign w_scan_last = (r_k == IDX_W'(NB_SPMS - 1));
    assign w_chk_addr  = (r_op == OP_DISABLE) ? r_req_pc : r_qaddr;
    assign w_enable_ok = (r_pub_s < r_pub_e) && (r_sec_s < r_sec_e) &&
                         !`SPM_OVERLAP(r_pub_s, r_pub_e, r_sec_s, r_sec_e) &&
                         !r_ovl && r_free;

    always_ff @(posedge mclk) begin
        if (!puc_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = '0;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_scan_last) w_state_nxt = ST_RESP;
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (r_op == OP_ENABLE && w_enable_ok) w_wr[r_free_idx] = 1'b1;
                if (r_op == OP_DISABLE && r_hit)      w_clr[r_hit_idx] = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            r_op <= OP_NONE;
            {r_pub_s, r_pub_e, r_sec_s, r_sec_e, r_qaddr, r_req_pc, r_prev_pc} <= '0;
            {r_k, r_free_idx, r_hit_idx} <= '0;
            {r_ovl, r_free, r_hit}       <= '0;
            r_next_id   <= ID_W'(1);
            r_data      <= '0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_violation <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_violation <= |w_viol;
            // Only a PC change moves history, so a stalled PC keeps its entry origin.
            if (pc != r_prev_pc) r_prev_pc <= pc;
            if (w_accept) begin
                r_op       <= spm_op_e'(req_op);
                r_pub_s    <= r12;
                r_pub_e    <= r13;
                r_sec_s    <= r14;
                r_sec_e    <= r15;
                r_qaddr    <= r15;
                r_req_pc   <= pc;
                r_k        <= '0;
                r_free_idx <= '0;
                r_hit_idx  <= '0;
                {r_ovl, r_free, r_hit} <= '0;
            end
            if (r_state == ST_SCAN) begin
                r_k <= r_k + 1'b1;
                if (r_op == OP_ENABLE) begin
                    if (w_en[r_k]) begin
                        if (w_overlaps[r_k]) r_ovl <= 1'b1;
                    end else if (!r_free) begin
                        r_free     <= 1'b1;
                        r_free_idx <= r_k;
                    end
                end else if (w_contains[r_k] && !r_hit) begin
                    r_hit     <= 1'b1;
                    r_hit_idx <= r_k;
                end
            end
            if (r_state == ST_RESP) begin
                r_done <= 1'b1;
                if (r_op == OP_ENABLE) begin
                    r_ok   <= w_enable_ok;
                    r_data <= w_enable_ok ? r_next_id : '0;
                    if (w_enable_ok)
                        r_next_id <= (r_next_id == '1) ? ID_W'(1) : r_next_id + 1'b1;
                end else begin
                    r_ok   <= r_hit;
                    r_data <= r_hit ? w_id[r_hit_idx] : '0;
                end
            end
        end
    end

    for (genvar g = 0; g < NB_SPMS; g++) begin : g_slot
        omsp_spm_slot #(
            .ADDR_W (ADDR_W),
            .ID_W   (ID_W)
        ) u_slot (
            .i_clk      (mclk),
            .i_rst_n    (puc_rst_n),
            .i_wr       (w_wr[g]),
            .i_clr      (w_clr[g]),
            .i_pub_s    (r_pub_s),
            .i_pub_e    (r_pub_e),
            .i_sec_s    (r_sec_s),
            .i_sec_e    (r_sec_e),
            .i_id       (r_next_id),
            .i_pc       (pc),
            .i_prev_pc  (r_prev_pc),
            .i_mab      (eu_mab),
            .i_mb_en    (eu_mb_en),
            .i_chk_addr (w_chk_addr),
            .o_en       (w_en[g]),
            .o_id       (w_id[g]),
            .o_contains (w_contains[g]),
            .o_overlaps (w_overlaps[g]),
            .o_viol     (w_viol[g])
        );
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign result_ok   = r_ok;
    assign result_data = r_data;
    assign violation   = r_violation;

endmodule

// File: tb/tb_omsp_spm_seq_ctrl.sv
// Scoreboarded bench for omsp_spm_seq_ctrl: requests push expected done results,
// a monitor branch pops them on each done pulse; violation is checked directly.
module tb_omsp_spm_seq_ctrl;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        puc_rst_n;
    logic [15:0] pc, eu_mab, r12, r13, r14, r15, result_data;
    logic        eu_mb_en, req_valid, busy, done, result_ok, violation;
    logic [1:0]  eu_mb_wr, req_op;

    typedef struct {
        logic        ok;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_exp;
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0, n_push = 0, n_done = 0;
    bit   stim_done = 1'b0;

    omsp_spm_seq_ctrl #(.NB_SPMS(NB), .ADDR_W(16), .ID_W(16)) dut (
        .mclk        (clk),
        .puc_rst_n   (puc_rst_n),
        .pc          (pc),
        .eu_mab      (eu_mab),
        .eu_mb_en    (eu_mb_en),
        .eu_mb_wr    (eu_mb_wr),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .r12         (r12),
        .r13         (r13),
        .r14         (r14),
        .r15         (r15),
        .busy        (busy),
        .done        (done),
        .result_ok   (result_ok),
        .result_data (result_data),
        .violation   (violation)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_sb();
        int i = 0;
        while (sb.size() != 0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL done_timeout: got %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic eok, input logic [15:0] edat);
        wait_idle();
        req_op = op; r12 = a; r13 = b; r14 = c; r15 = d;
        req_valid = 1'b1;
        sb.push_back('{eok, edat, cyc + NB + 2});
        n_push++;
        step(1);
        req_valid = 1'b0;
        req_op    = 2'b00;
        wait_sb();
    endtask

    task automatic vchk(input string name, input int exp);
        step(1);
        chk(name, int'(violation), exp);
    endtask

    initial begin
        puc_rst_n = 1'b0; pc = 16'h4000; eu_mab = 16'h0000; eu_mb_en = 1'b0; eu_mb_wr = 2'b00;
        req_valid = 1'b0; req_op = 2'b00; r12 = '0; r13 = '0; r14 = '0; r15 = '0;
        step(3);
        fork
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    if (done === 1'b1) begin
                        n_done++;
                        n_tests++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                        end else begin
                            m_exp = sb.pop_front();
                            if (result_ok !== m_exp.ok || result_data !== m_exp.data || cyc != m_exp.cyc) begin
                                n_fail++;
                                $display("FAIL done_result: got ok=%0b data=0x%0h cycle=%0d, required ok=%0b data=0x%0h cycle=%0d",
                                         result_ok, result_data, cyc, m_exp.ok, m_exp.data, m_exp.cyc);
                            end
                        end
                    end
                end
            end
            begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_ok", int'(result_ok), 0);
                chk("rst_data", int'(result_data), 0);
                chk("rst_violation", int'(violation), 0);
                puc_rst_n = 1'b1;
                step(1);

                issue(2'b01, 16'h8000, 16'h8100, 16'h0200, 16'h0300, 1'b1, 16'd1);
                issue(2'b01, 16'h9000, 16'h9100, 16'h0400, 16'h0500, 1'b1, 16'd2);
                issue(2'b01, 16'hA000, 16'hA100, 16'h0280, 16'h0380, 1'b0, 16'd0);
                issue(2'b01, 16'hA000, 16'hA000, 16'h0600, 16'h0700, 1'b0, 16'd0);
                issue(2'b01, 16'hD000, 16'hD100, 16'hD080, 16'hD200, 1'b0, 16'd0);
                issue(2'b01, 16'hA000, 16'hA100, 16'h0600, 16'h0700, 1'b1, 16'd3);
                issue(2'b01, 16'hB000, 16'hB100, 16'h0800, 16'h0900, 1'b1, 16'd4);
                issue(2'b01, 16'hC000, 16'hC100, 16'h0A00, 16'h0B00, 1'b0, 16'd0);
                issue(2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h9050, 1'b1, 16'd2);
                issue(2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h8100, 1'b0, 16'd0);
                pc = 16'h8010;
                issue(2'b10, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'd1);
                issue(2'b01, 16'h8000, 16'h8100, 16'h0200, 16'h0300, 1'b1, 16'd5);
                issue(2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b1, 16'd5);

                // Access and entry-point checks against slot 0: pub [8000,8100), sec [0200,0300)
                pc = 16'h4000;
                step(2);
                eu_mb_en = 1'b1; eu_mab = 16'h0210;
                vchk("viol_secret_outside", 1);
                eu_mb_en = 1'b0;
                vchk("viol_cleared", 0);
                eu_mb_en = 1'b1; eu_mab = 16'h0300;
                vchk("viol_sec_end_excl", 0);
                eu_mb_en = 1'b0; pc = 16'h8000;
                vchk("viol_entry_at_start", 0);
                pc = 16'h8004; eu_mb_en = 1'b1; eu_mab = 16'h0210;
                vchk("viol_secret_inside", 0);
                eu_mb_en = 1'b0; pc = 16'h4000;
                vchk("viol_leave", 0);
                pc = 16'h8002;
                vchk("viol_bad_entry", 1);
                vchk("viol_hold1", 0);
                vchk("viol_hold2", 0);
                vchk("viol_hold3", 0);

                // Requests presented while busy must be dropped.
                wait_idle();
                pc = 16'h8000; req_op = 2'b11; r15 = 16'h9050; req_valid = 1'b1;
                sb.push_back('{1'b1, 16'd2, cyc + NB + 2});
                n_push++;
                step(1);
                req_op = 2'b10;
                chk("busy_after_accept", int'(busy), 1);
                step(2);
                req_valid = 1'b0; req_op = 2'b00;
                wait_sb();

                // Reset during SCAN aborts with no done and clears all slots.
                req_op = 2'b11; r15 = 16'h8000; req_valid = 1'b1;
                step(1);
                req_valid = 1'b0; req_op = 2'b00;
                step(1);
                puc_rst_n = 1'b0;
                step(2);
                chk("midrst_busy", int'(busy), 0);
                chk("midrst_done", int'(done), 0);
                puc_rst_n = 1'b1;
                step(10);
                issue(2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 16'd0);
                issue(2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h9050, 1'b0, 16'd0);
                issue(2'b01, 16'h8000, 16'h8100, 16'h0200, 16'h0300, 1'b1, 16'd1);
                step(3);
                stim_done = 1'b1;
            end
        join
        chk("done_count", n_done, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/omsp_spm_seq_ctrl.md
Name: omsp_spm_seq_ctrl

Overview:
Parametrised, sequential successor to the combinational SPM controller. It owns NB_SPMS protected-module slots and runs enable, disable and query requests through a scanning FSM, one slot per cycle, so timing does not grow with slot count. It assigns monotonically increasing module IDs and flags memory-access and entry-point violations every cycle. It sits beside the execution unit and is fed by the CPU register file and the memory bus.

Parameters:
NB_SPMS, 4, number of module slots (1..16)
ADDR_W, 16, address/PC width
ID_W, 16, module ID width; ID 0 is reserved for "none"

Ports:
mclk  in  1  system clock
puc_rst_n  in  1  synchronous active-low reset
pc  in  ADDR_W  current program counter
eu_mab  in  ADDR_W  execution-unit memory address
eu_mb_en  in  1  memory bus enable
eu_mb_wr  in  2  byte write strobes
req_valid  in  1  request strobe, sampled only when busy=0
req_op  in  2  01 enable, 10 disable, 11 query, 00 ignored
r12, r13, r14, r15  in  ADDR_W each  operands (pub_start, pub_end, sec_start, sec_end; r15 = query address)
busy  out  1  FSM not IDLE
done  out  1  one-cycle completion pulse
result_ok  out  1  valid with done
result_data  out  ID_W  valid with done
violation  out  1  registered access/entry violation pulse

Behaviour:
- Clock and reset: one clock, mclk. Reset puc_rst_n is synchronous and active-low.
- Reset: all slots disabled, regions cleared, next_id=1, FSM=IDLE, busy/done/result_ok/violation=0, result_data=0, prev_pc=0. Reset mid-operation aborts the operation with no done pulse.
- Regions are half-open [start,end). A region is valid iff start<end (unsigned). Ranges [a,b) and [c,d) overlap iff a<d && c<b.
- IDLE: on req_valid with op≠00, latch op, r12–r15 and pc into req regs. Next state is SCAN with k=0. busy rises the following cycle. While busy=1, req_valid is ignored (no queueing).
- SCAN: examines slot k each cycle, k=0..NB_SPMS-1, then moves to RESP. Total latency from accept to done is NB_SPMS+2 cycles.
  - enable: sets an overlap flag if slot k is enabled and any of its pub/sec regions overlaps the new pub or sec region. Records the first disabled slot index.
  - disable: records the first enabled slot whose public region contains the latched pc.
  - query: records the first enabled slot whose public region contains r15.
- RESP: asserts done for one cycle, then returns to IDLE.
  - enable success requires: both regions valid, pub and sec not overlapping each other, no overlap flag, and a free slot found. On success, commit the slot and its ID, result_ok=1, result_data=ID, and increment next_id. next_id wraps from 2^ID_W-1 to 1, never 0.
  - enable failure: result_ok=0, result_data=0.
  - disable hit: clear the slot, result_ok=1, result_data=its ID. Miss: result_ok=0, result_data=0.
  - query hit: result_ok=1, result_data=ID. Miss: result_ok=0, result_data=0.
- Access check runs every cycle, registered, in all FSM states, and uses committed slots only. A slot committed in RESP is checked from the next cycle.
  - Secret access: eu_mb_en=1 with eu_mab in an enabled slot's sec region while pc is outside that slot's pub region.
  - Entry point: pc inside a slot's pub region, prev_pc outside it, and pc≠pub_start.
  - Result: violation=1 on the next cycle.
- prev_pc/cur_pc registers update only when pc≠cur_pc, so stalls do not erase history.
- A slot disabled in RESP stops being checked in the next cycle.

Decomposition:
- Shared defines file holds: op codes (OP_NONE/ENABLE/DISABLE/QUERY), FSM state encodings (IDLE/SCAN/RESP), and the region-overlap and containment macros.
- One natural sub-module, omsp_spm_slot. It is instantiated NB_SPMS times and holds the enable bit, four bounds and the ID. It computes its own per-cycle violation and the contains(addr) / overlaps(range) outputs used by the scan mux.

Test Plan:
- Reset, then enable with r12=0x8000, r13=0x8100, r14=0x0200, r15=0x0300, NB_SPMS=4 -> done at cycle 6 after accept, result_ok=1, result_data=1. A second disjoint enable returns ID 2.
- Enable overlapping an existing sec range (r14=0x0280) -> result_ok=0, result_data=0, next_id unchanged. Enable with r12=r13 -> fail.
- Fill all 4 slots, then issue a fifth valid enable -> fail. Disable with pc=0x8010 -> result_data=1. Re-enable -> slot 0 reused with ID 5.
- With pc=0x4000, eu_mb_en=1, eu_mab=0x0210 -> violation=1 next cycle. Same access with pc=0x8004 -> violation=0.
- pc jumps 0x4000→0x8002 -> violation. pc 0x4000→0x8000 -> none. pc held at 0x8002 for 3 cycles -> no repeat violation.
- Assert puc_rst_n=0 during SCAN -> no done, busy=0, all slots cleared. A subsequent query of 0x8000 -> result_ok=0. req_valid while busy is ignored.
